// File: rtl/alu_issue_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_issue_stage : decode, 8-entry regfile read, RAW/WAW scoreboard, ALU issue
// Optional writeback bypass: define ALU_ISSUE_FORWARD_EN.        Rev 1.0
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [15:0]  in_instr,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_a,
  output logic [N-1:0] out_b,
  output logic [3:0]   out_opcode,
  output logic [2:0]   out_rd,
  input  logic         wb_en,
  input  logic [2:0]   wb_rd,
  input  logic [N-1:0] wb_data,
  output logic [15:0]  stall_cnt
);

  localparam logic [3:0]  C_LAST_OP = 4'd10;
  localparam logic [15:0] C_SAT     = 16'hFFFF;

  logic [N-1:0] r_rf [8];
  logic [7:0]   r_pend;

  logic [3:0]   w_op;
  logic [2:0]   w_rd;
  logic [2:0]   w_rs1;
  logic [2:0]   w_rs2;
  logic         w_unused;
  logic         w_op_valid;
  logic [7:0]   w_wb_hit;
  logic [7:0]   w_pend_eff;
  logic         w_hazard;
  logic         w_free;
  logic         w_accept;
  logic         w_issue;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;

  assign w_op       = in_instr[15:12];
  assign w_rd       = in_instr[11:9];
  assign w_rs1      = in_instr[8:6];
  assign w_rs2      = in_instr[5:3];
  assign w_unused   = ^in_instr[2:0];
  assign w_op_valid = (w_op <= C_LAST_OP);
  assign w_wb_hit   = wb_en ? (8'd1 << wb_rd) : 8'd0;

`ifdef ALU_ISSUE_FORWARD_EN
  // A writeback landing this cycle resolves its tag, so it no longer blocks.
  assign w_pend_eff = r_pend & ~w_wb_hit;
  assign w_a        = w_wb_hit[w_rs1] ? wb_data : r_rf[w_rs1];
  assign w_b        = w_wb_hit[w_rs2] ? wb_data : r_rf[w_rs2];
`else
  assign w_pend_eff = r_pend;
  assign w_a        = r_rf[w_rs1];
  assign w_b        = r_rf[w_rs2];
`endif

  assign w_hazard = w_op_valid &
                    (w_pend_eff[w_rs1] | w_pend_eff[w_rs2] | w_pend_eff[w_rd]);
  assign w_free   = !out_valid | out_ready;
  assign in_ready = w_free & !w_hazard;
  assign w_accept = in_valid & in_ready;
  assign w_issue  = w_accept & w_op_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= '0;
      end
      r_pend     <= 8'd0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_opcode <= 4'd0;
      out_rd     <= 3'd0;
      stall_cnt  <= 16'd0;
    end else begin
      if (wb_en) begin
        r_rf[wb_rd] <= wb_data;
      end
      // Set is applied after clear so a same-cycle set on the same bit wins.
      r_pend <= (r_pend & ~w_wb_hit) | (w_issue ? (8'd1 << w_rd) : 8'd0);

      if (w_issue) begin
        out_valid  <= 1'b1;
        out_a      <= w_a;
        out_b      <= w_b;
        out_opcode <= w_op;
        out_rd     <= w_rd;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end

      if (in_valid && !in_ready && stall_cnt != C_SAT) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized
// run against a cycle-level reference model of the issue rules.
module tb_alu_issue_stage;
  localparam int N = 16;
`ifdef ALU_ISSUE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [15:0]  in_instr;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_a;
  logic [N-1:0] out_b;
  logic [3:0]   out_opcode;
  logic [2:0]   out_rd;
  logic         wb_en;
  logic [2:0]   wb_rd;
  logic [N-1:0] wb_data;
  logic [15:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_opcode(out_opcode), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_instr = 16'h0000; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = 3'd0; wb_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic write_back(input logic [2:0] r, input logic [N-1:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    checks++; if (out_a !== 16'h0) begin errors++; $display("FAIL reset_out_a got %0h want 0", out_a); end
    checks++; if (out_b !== 16'h0) begin errors++; $display("FAIL reset_out_b got %0h want 0", out_b); end
    checks++; if (out_opcode !== 4'h0) begin errors++; $display("FAIL reset_out_opcode got %0h want 0", out_opcode); end
    checks++; if (out_rd !== 3'h0) begin errors++; $display("FAIL reset_out_rd got %0h want 0", out_rd); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
    checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt got %0h want 0", stall_cnt); end
  endtask

  task automatic test_basic_issue();
    do_reset();
    write_back(3'd1, 16'd5);
    write_back(3'd2, 16'd3);
    in_valid = 1'b1; in_instr = 16'h0650;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0h want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0h want 1", out_valid); end
    checks++; if (out_a !== 16'd5) begin errors++; $display("FAIL basic_out_a got %0h want 5", out_a); end
    checks++; if (out_b !== 16'd3) begin errors++; $display("FAIL basic_out_b got %0h want 3", out_b); end
    checks++; if (out_opcode !== 4'd0) begin errors++; $display("FAIL basic_out_opcode got %0h want 0", out_opcode); end
    checks++; if (out_rd !== 3'd3) begin errors++; $display("FAIL basic_out_rd got %0h want 3", out_rd); end
  endtask

  task automatic test_raw();
    do_reset();
    write_back(3'd1, 16'd5);
    write_back(3'd2, 16'd3);
    in_valid = 1'b1; in_instr = 16'h0650;
    step();
    in_instr = 16'h18C8;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_ready got %0h want 0", in_ready); end
    step();
    wb_en = 1'b1; wb_rd = 3'd3; wb_data = 16'd8;
    #1;
    checks++; if (in_ready !== FWD) begin errors++; $display("FAIL raw_wb_cycle_ready got %0h want %0h", in_ready, FWD); end
    step();
    wb_en = 1'b0;
    checks++; if (out_valid !== FWD) begin errors++; $display("FAIL raw_wb_edge_valid got %0h want %0h", out_valid, FWD); end
    checks++; if (out_rd !== (FWD ? 3'd4 : 3'd3)) begin errors++; $display("FAIL raw_wb_edge_rd got %0h want %0h", out_rd, (FWD ? 3'd4 : 3'd3)); end
    in_valid = !FWD;
    #1;
    checks++; if (in_ready !== !FWD) begin errors++; $display("FAIL raw_after_wb_ready got %0h want %0h", in_ready, !FWD); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== !FWD) begin errors++; $display("FAIL raw_final_valid got %0h want %0h", out_valid, !FWD); end
    checks++; if (out_a !== 16'd8) begin errors++; $display("FAIL raw_out_a got %0h want 8", out_a); end
    checks++; if (out_b !== 16'd5) begin errors++; $display("FAIL raw_out_b got %0h want 5", out_b); end
    checks++; if (out_opcode !== 4'd1) begin errors++; $display("FAIL raw_out_opcode got %0h want 1", out_opcode); end
    checks++; if (out_rd !== 3'd4) begin errors++; $display("FAIL raw_out_rd got %0h want 4", out_rd); end
    checks++; if (stall_cnt !== (FWD ? 16'd1 : 16'd2)) begin errors++; $display("FAIL raw_stall_cnt got %0d want %0d", stall_cnt, (FWD ? 1 : 2)); end
  endtask

  task automatic test_backpressure();
    do_reset();
    write_back(3'd1, 16'd5);
    write_back(3'd2, 16'd3);
    in_valid = 1'b1; in_instr = 16'h0650;
    step();
    out_ready = 1'b0; in_instr = 16'h0A50;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0h want 0", i, in_ready); end
      step();
      checks++; if ({out_valid, out_a, out_b, out_opcode, out_rd} !== {1'b1, 16'd5, 16'd3, 4'd0, 3'd3})
        begin errors++; $display("FAIL bp_hold[%0d] got v%0h a%0h b%0h op%0h rd%0h want v1 a5 b3 op0 rd3", i, out_valid, out_a, out_b, out_opcode, out_rd); end
    end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL bp_stall_cnt got %0d want 4", stall_cnt); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0h want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 3'd5) begin errors++; $display("FAIL bp_next_issue got v%0h rd%0h want v1 rd5", out_valid, out_rd); end
  endtask

  task automatic test_nop_waw();
    do_reset();
    write_back(3'd1, 16'd5);
    write_back(3'd2, 16'd3);
    in_valid = 1'b1; in_instr = 16'hFA50;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nop_ready got %0h want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nop_out_valid got %0h want 0", out_valid); end
    in_instr = 16'h0A50;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nop_no_pend got %0h want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b1 || out_rd !== 3'd5) begin errors++; $display("FAIL waw_first got v%0h rd%0h want v1 rd5", out_valid, out_rd); end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_stall[%0d] got %0h want 0", i, in_ready); end
      step();
    end
    wb_en = 1'b1; wb_rd = 3'd5; wb_data = 16'h1234;
    #1;
    checks++; if (in_ready !== FWD) begin errors++; $display("FAIL waw_wb_ready got %0h want %0h", in_ready, FWD); end
    step();
    wb_en = 1'b0;
    in_valid = !FWD;
    #1;
    checks++; if (in_ready !== !FWD) begin errors++; $display("FAIL waw_after_wb_ready got %0h want %0h", in_ready, !FWD); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== !FWD) begin errors++; $display("FAIL waw_final_valid got %0h want %0h", out_valid, !FWD); end
    checks++; if (out_rd !== 3'd5 || out_a !== 16'd5) begin errors++; $display("FAIL waw_second got rd%0h a%0h want rd5 a5", out_rd, out_a); end
    checks++; if (stall_cnt !== (FWD ? 16'd2 : 16'd3)) begin errors++; $display("FAIL waw_stall_cnt got %0d want %0d", stall_cnt, (FWD ? 2 : 3)); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    write_back(3'd3, 16'd7);
    write_back(3'd1, 16'd5);
    in_valid = 1'b1; in_instr = 16'h0650;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0h want 1", out_valid); end
    out_ready = 1'b0; rst_n = 1'b0;
    wb_en = 1'b1; wb_rd = 3'd3; wb_data = 16'd9;
    step();
    rst_n = 1'b1; out_ready = 1'b1; wb_en = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %0h want 0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_stall_cnt got %0d want 0", stall_cnt); end
    in_valid = 1'b1; in_instr = 16'h18C8;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_pend_clear got %0h want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_a !== 16'd0 || out_b !== 16'd0)
      begin errors++; $display("FAIL mid_read_r3 got v%0h a%0h b%0h want v1 a0 b0", out_valid, out_a, out_b); end
  endtask

  task automatic test_random();
    logic [N-1:0] m_rf [8];
    bit           m_pend [8];
    bit           m_ov;
    logic [N-1:0] m_a, m_b;
    logic [3:0]   m_op, op;
    logic [2:0]   m_rd, rd, rs1, rs2;
    int           m_stall;
    bit           busy1, busy2, busy3, exp_rdy, acc;
    do_reset();
    for (int i = 0; i < 8; i++) begin m_rf[i] = '0; m_pend[i] = 1'b0; end
    m_ov = 1'b0; m_a = '0; m_b = '0; m_op = 4'd0; m_rd = 3'd0; m_stall = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      op  = 4'($urandom_range(0, 15));
      rd  = 3'($urandom_range(0, 7));
      rs1 = 3'($urandom_range(0, 7));
      rs2 = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = {op, rd, rs1, rs2, 3'($urandom_range(0, 7))};
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_rd     = 3'($urandom_range(0, 7));
      wb_data   = N'($urandom);
      #1;
      // A source is busy if pending, unless a same-cycle writeback is bypassed.
      busy1 = m_pend[rs1] && !(FWD && wb_en && wb_rd == rs1);
      busy2 = m_pend[rs2] && !(FWD && wb_en && wb_rd == rs2);
      busy3 = m_pend[rd]  && !(FWD && wb_en && wb_rd == rd);
      exp_rdy = (!m_ov || out_ready) && !((op <= 4'd10) && (busy1 || busy2 || busy3));
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready cyc %0d got %0h want %0h", cyc, in_ready, exp_rdy); end
      if (in_valid && !exp_rdy && m_stall < 65535) m_stall++;
      acc = in_valid && exp_rdy && (op <= 4'd10);
      if (acc) begin
        m_a  = (FWD && wb_en && wb_rd == rs1) ? wb_data : m_rf[rs1];
        m_b  = (FWD && wb_en && wb_rd == rs2) ? wb_data : m_rf[rs2];
        m_op = op; m_rd = rd; m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (wb_en) begin m_pend[wb_rd] = 1'b0; m_rf[wb_rd] = wb_data; end
      if (acc) m_pend[rd] = 1'b1;
      step();
      checks++; if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid cyc %0d got %0h want %0h", cyc, out_valid, m_ov); end
      checks++; if ({out_a, out_b} !== {m_a, m_b}) begin errors++; $display("FAIL rnd_operands cyc %0d got %0h/%0h want %0h/%0h", cyc, out_a, out_b, m_a, m_b); end
      checks++; if ({out_opcode, out_rd} !== {m_op, m_rd}) begin errors++; $display("FAIL rnd_op_rd cyc %0d got %0h/%0h want %0h/%0h", cyc, out_opcode, out_rd, m_op, m_rd); end
      checks++; if (stall_cnt !== 16'(m_stall)) begin errors++; $display("FAIL rnd_stall_cnt cyc %0d got %0d want %0d", cyc, stall_cnt, m_stall); end
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_basic_issue();
    test_raw();
    test_backpressure();
    test_nop_waw();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue stage sitting directly upstream of the parameterized ALU in the pipelined mini-CPU. Accepts 16-bit instructions over a valid/ready handshake, decodes them, reads an internal 8-entry register file and presents registered `A`, `B` and `opcode` to the ALU. A per-register scoreboard, cleared by the downstream writeback port, enforces read-after-write (RAW) and write-after-write (WAW) ordering. An optional bypass path forwards writeback data into the issue cycle.

## Interface
- `N`, 16, data width; matches the ALU `N`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  instruction present.
- `in_instr`  in  16  fields: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] ignored.
- `in_ready`  out  1  stage accepts `in_instr` this cycle.
- `out_valid`  out  1  issued operation present toward the ALU.
- `out_ready`  in  1  ALU/EX register consumes the issued operation.
- `out_a`, `out_b`  out  N  operands: value of rs1 and value of rs2.
- `out_opcode`  out  4  ALU opcode.
- `out_rd`  out  3  destination tag, travels with the operation.
- `wb_en`  in  1  writeback strobe from downstream.
- `wb_rd`  in  3  writeback register.
- `wb_data`  in  N  writeback value.
- `stall_cnt`  out  16  saturating count of stalled cycles.

## Operation
- Register file: 8×N, all entries writable (r0 is not hardwired). Written on `wb_en`.
- Scoreboard: `pend[7:0]`.
  - Set `pend[rd]` on acceptance of a valid opcode.
  - Clear `pend[wb_rd]` on `wb_en`.
  - If a set and a clear target the same bit in the same cycle, set wins.
- Valid opcodes: 0000–1010. Opcodes 1011–1111 are NOPs:
  - accepted subject to the backpressure term only;
  - never issued (no `out_valid`);
  - no scoreboard change.
- Hazard, evaluated on `in_instr` for valid opcodes: `hazard = pend[rs1] | pend[rs2] | pend[rd]`, after the bypass rule below is applied.
- Backpressure term: `free = !out_valid | out_ready`.
- `in_ready = free & !hazard`. For NOPs, `in_ready = free`.
- Acceptance occurs when `in_valid & in_ready`. On acceptance of a valid opcode:
  - capture operands, `out_opcode` and `out_rd`;
  - set `out_valid = 1`.
- When `out_valid & out_ready` and no new acceptance occurs, clear `out_valid`. Outputs hold their last values.
- When `out_valid & !out_ready`, all `out_*` signals hold stable.
- Operand read with a same-cycle writeback (`wb_en`, `wb_rd == rs`):
  - with forwarding, take `wb_data` and treat that source as not pending;
  - without forwarding, take the file value, which is the old value. The source is still pending that cycle, so the instruction stalls anyway.
- `stall_cnt` increments in each cycle where `in_valid & !in_ready`. It saturates at 0xFFFF.

## Timing
- Latency: an instruction accepted in cycle t drives `out_*` in cycle t+1.
- Throughput: one instruction per cycle when there is no hazard and `out_ready = 1`.
- RAW turnaround (producer accepted at t, writeback at w):
  - with forwarding, the consumer can be accepted at w;
  - without forwarding, the earliest consumer acceptance is w+1.
- Reset (`rst_n` low at a rising edge) applies regardless of other inputs:
  - regfile all 0, `pend` = 0;
  - `out_valid` = 0, `out_a` = `out_b` = 0, `out_opcode` = 0, `out_rd` = 0;
  - `stall_cnt` = 0;
  - `wb_en` is ignored.
- Reset mid-operation discards any issued operation. Any later `wb_en` for a pre-reset tag writes the file and clears an already-clear bit. This is harmless.
- Combinational paths:
  - `in_ready` depends combinationally on `out_ready`, `wb_en`/`wb_rd` (with forwarding only) and `in_instr`.
  - `out_*` are registered only.

## Configuration
- `ALU_ISSUE_FORWARD_EN` defined:
  - bypass mux from `wb_data` to `out_a`/`out_b`;
  - a same-cycle matching writeback masks the pending bit of that source, and of rd for WAW.
- `ALU_ISSUE_FORWARD_EN` undefined:
  - no bypass; pending bits are honoured as-is;
  - the consumer waits one extra cycle after writeback.
- Port list is identical in both builds.

## Test plan
- Reset, then idle. Required: all outputs 0, `in_ready = 1`, `stall_cnt = 0`.
- Seed r1 = 5 and r2 = 3 via `wb_en`, then issue ADD r3,r1,r2 (0x0650). Required at the next cycle: `out_valid = 1`, `out_a = 5`, `out_b = 3`, `out_opcode = 0`, `out_rd = 3`.
- RAW case: issue ADD r3,r1,r2, then SUB r4,r3,r1 (0x18C8); return wb r3 = 8 two cycles later.
  - Forwarding build: SUB accepted in the wb cycle with `out_a = 8`.
  - Non-forwarding build: SUB accepted one cycle later.
  - In both builds, `stall_cnt` equals the number of stalled cycles.
- Backpressure: hold `out_ready = 0` for 4 cycles while `out_valid = 1`. Required: `out_*` stable, `in_ready = 0`, `stall_cnt` +4. On release, the next instruction is issued in the following cycle.
- NOP and WAW: opcode 1111 is accepted with no `out_valid` and no `pend` change. Two back-to-back writes to r5 stall the second until r5's writeback.
- Reset mid-flight: assert reset with `out_valid = 1` and `pend[3] = 1`. Required: `out_valid = 0`, `pend` = 0, and a following read of r3 returns 0.
